// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM states,
// response error codes and the per-op latency helper.
package alu_op_sequencer_pkg;

  // ALUControl opcodes. 1101..1111 are illegal.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_SHRA = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_NEG  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;

  // Response error codes.
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;

  // Latency counter width; latencies up to 256 cycles are representable.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_ROR;
  endfunction

  // Counter load value is LAT(op)-1 so that done (cnt==0) marks the last EXEC cycle.
  function automatic logic [CNT_W-1:0] lat_load(input logic [3:0] op,
                                                 input int unsigned lat_simple,
                                                 input int unsigned lat_mul,
                                                 input int unsigned lat_div);
    int unsigned lat;
    lat = lat_simple;
    if (op == OP_MUL) lat = lat_mul;
    else if (op == OP_DIV) lat = lat_div;
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-side and response signals of the op sequencer.
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high; valid never waits on ready, and the sender keeps its payload
// stable while valid is high and ready is low.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_out;
  logic        alu_zero;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        z_zero;
  logic [1:0]  resp_err;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, alu_out, alu_zero, resp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, resp_valid, z_hi, z_lo, z_zero, resp_err
  );

  // Requester / ALU / consumer side.
  modport master (
    output req_valid, req_op, req_a, req_b, flush, alu_out, alu_zero, resp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, resp_valid, z_hi, z_lo, z_zero, resp_err
  );
endinterface

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that times the EXEC phase; done marks cnt==0.
module alu_lat_counter
  import alu_op_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load on issue, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller for the external 64-bit-result ALU.
// Accepts an op, holds the ALU inputs for the op latency, captures ALUOut
// into the Z register and returns it over a response handshake.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned LAT_SIMPLE = 1,
  parameter int unsigned LAT_MUL    = 4,
  parameter int unsigned LAT_DIV    = 8
) (
  input  logic                clock,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output state_t              fsm_state
);

  state_t state, state_next;

  logic accept;
  logic load;
  logic capture;
  logic reject_ill;
  logic reject_div0;
  logic done;

  alu_lat_counter u_lat (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (lat_load(bus.req_op, LAT_SIMPLE, LAT_MUL, LAT_DIV)),
    .dec      (state == ST_EXEC),
    .done     (done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, handshake outputs and register-update strobes.
  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    accept         = 1'b0;
    load           = 1'b0;
    capture        = 1'b0;
    reject_ill     = 1'b0;
    reject_div0    = 1'b0;
    case (state)
      ST_IDLE: begin
        // flush is meaningless here; a concurrent request is still taken.
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (!op_legal(bus.req_op)) begin
            reject_ill = 1'b1;
            state_next = ST_RESP;
          end else if ((bus.req_op == OP_DIV) && (bus.req_b == '0)) begin
            reject_div0 = 1'b1;
            state_next  = ST_RESP;
          end else begin
            load       = 1'b1;
            state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else if (done) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.flush || bus.resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latch on accept; Z/error update on capture or reject only.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_ctrl <= '0;
      bus.z_hi     <= '0;
      bus.z_lo     <= '0;
      bus.z_zero   <= 1'b0;
      bus.resp_err <= ERR_OK;
    end else begin
      if (accept) begin
        bus.alu_a    <= bus.req_a;
        bus.alu_b    <= bus.req_b;
        bus.alu_ctrl <= bus.req_op;
      end
      if (reject_ill || reject_div0) begin
        bus.z_hi     <= '0;
        bus.z_lo     <= '0;
        bus.z_zero   <= 1'b0;
        bus.resp_err <= reject_ill ? ERR_ILL : ERR_DIV0;
      end else if (capture) begin
        bus.z_hi     <= bus.alu_out[63:32];
        bus.z_lo     <= bus.alu_out[31:0];
        bus.z_zero   <= bus.alu_zero;
        bus.resp_err <= ERR_OK;
      end
    end
  end

  assign fsm_state = state;

endmodule
